// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Owner encoding tags which requester issued the access whose read data returns next cycle.
package arb_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CORE = 2'd1,
      OWNER_DMA  = 2'd2
   } owner_t;

   localparam logic [15:0] DEFAULT_DISPLAY_ADDR = 16'hFFFF;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter that tracks how long the DMA has been denied.
// The counter holds at p_LIMIT until it is cleared by a grant or by reset.
module starve_counter #(
   parameter int p_LIMIT = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         inc,
   input  logic                         clr,
   output logic [$clog2(p_LIMIT+1)-1:0] count,
   output logic                         at_limit
);

   localparam int CW = $clog2(p_LIMIT + 1);

   assign at_limit = (count == CW'(p_LIMIT));

   // NOTE: sequential state is written only with non-blocking assignments so every
   // reader of count sees the value from before the edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates one data-memory port between the core and a DMA engine, with a
// memory-mapped display register and a starvation bound that eventually stalls the core.
module data_mem_arbiter
   import arb_pkg::*;
#(
   parameter int          p_WORD_LEN     = 16,
   parameter int          p_ADDR_LEN     = 10,
   parameter int          p_STARVE_LIMIT = 8,
   parameter logic [15:0] p_DISPLAY_ADDR = DEFAULT_DISPLAY_ADDR
) (
   input  logic                  i_clk,
   input  logic                  i_rst,

   input  logic                  i_core_req,
   input  logic                  i_core_wr_en,
   input  logic [15:0]           i_core_addr,
   input  logic [p_WORD_LEN-1:0] i_core_wr_data,
   output logic [p_WORD_LEN-1:0] o_core_rd_data,
   output logic                  o_core_stall,

   input  logic                  i_dma_req,
   input  logic                  i_dma_wr_en,
   input  logic [15:0]           i_dma_addr,
   input  logic [p_WORD_LEN-1:0] i_dma_wr_data,
   output logic                  o_dma_gnt,
   output logic [p_WORD_LEN-1:0] o_dma_rd_data,
   output logic                  o_dma_rd_valid,

   output logic [p_ADDR_LEN-1:0] o_mem_addr,
   output logic                  o_mem_wr_en,
   output logic [p_WORD_LEN-1:0] o_mem_wr_data,
   input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
   output logic [p_WORD_LEN-1:0] o_display
);

   localparam int SW = $clog2(p_STARVE_LIMIT + 1);

   function automatic logic in_range(input logic [15:0] addr);
      return (addr >> p_ADDR_LEN) == 16'd0;
   endfunction

   logic                  dma_gnt;
   logic                  core_gnt;
   logic                  any_gnt;
   logic                  sel_wr;
   logic [15:0]           sel_addr;
   logic [p_WORD_LEN-1:0] sel_data;
   logic                  disp_wr;
   logic [SW-1:0]         r_starve;
   logic                  starve_full;

   owner_t                r_owner;
   logic [15:0]           r_prev_addr;
   logic                  r_prev_wr;
   logic [p_WORD_LEN-1:0] r_display;
   logic [p_WORD_LEN-1:0] rd_map;

   starve_counter #(
      .p_LIMIT (p_STARVE_LIMIT)
   ) u_starve (
      .clk      (i_clk),
      .rst      (i_rst),
      .inc      (i_dma_req && !dma_gnt),
      .clr      (dma_gnt),
      .count    (r_starve),
      .at_limit (starve_full)
   );

   // The core normally wins; the DMA only overrides it once it has waited the full limit.
   always_comb begin
      dma_gnt  = !i_rst && i_dma_req && (!i_core_req || starve_full);
      core_gnt = !i_rst && i_core_req && !dma_gnt;
      any_gnt  = dma_gnt || core_gnt;
   end

   // NOTE: every always_comb output gets an unconditional default first so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      sel_wr   = 1'b0;
      sel_addr = i_core_addr;
      sel_data = i_core_wr_data;
      if (dma_gnt) begin
         sel_wr   = i_dma_wr_en;
         sel_addr = i_dma_addr;
         sel_data = i_dma_wr_data;
      end else if (core_gnt) begin
         sel_wr   = i_core_wr_en;
      end
   end

   assign o_dma_gnt     = dma_gnt;
   assign o_core_stall  = i_core_req && dma_gnt;
   assign o_mem_addr    = sel_addr[p_ADDR_LEN-1:0];
   assign o_mem_wr_data = sel_data;
   assign o_mem_wr_en   = any_gnt && sel_wr && in_range(sel_addr);
   assign disp_wr       = any_gnt && sel_wr && (sel_addr == p_DISPLAY_ADDR);
   assign o_display     = r_display;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner     <= OWNER_NONE;
         r_prev_addr <= '0;
         r_prev_wr   <= 1'b0;
         r_display   <= '0;
      end else begin
         r_owner     <= dma_gnt ? OWNER_DMA : (core_gnt ? OWNER_CORE : OWNER_NONE);
         r_prev_addr <= sel_addr;
         r_prev_wr   <= sel_wr;
         if (disp_wr) begin
            r_display <= sel_data;
         end
      end
   end

   // Read data for last cycle's access: memory when in range, else the display register.
   always_comb begin
      rd_map = '0;
      if (in_range(r_prev_addr)) begin
         rd_map = i_mem_rd_data;
      end else if (r_prev_addr == p_DISPLAY_ADDR) begin
         rd_map = r_display;
      end
   end

   // Outputs are masked during reset so a read granted just before reset never surfaces.
   always_comb begin
      o_core_rd_data = '0;
      o_dma_rd_valid = 1'b0;
      o_dma_rd_data  = '0;
      if (!i_rst) begin
         if (r_owner == OWNER_CORE) begin
            o_core_rd_data = rd_map;
         end
         if (r_owner == OWNER_DMA && !r_prev_wr) begin
            o_dma_rd_valid = 1'b1;
            o_dma_rd_data  = rd_map;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model with a flat shadow memory.
module tb_data_mem_arbiter;

   localparam int          LIMIT = 8;
   localparam int          DEPTH = 1024;
   localparam logic [15:0] DISP  = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_wr_en, dma_req, dma_wr_en;
   logic [15:0] core_addr, core_wr_data, dma_addr, dma_wr_data;
   logic [15:0] core_rd_data, dma_rd_data, mem_wr_data, mem_rd_data, display;
   logic        core_stall, dma_gnt, dma_rd_valid, mem_wr_en;
   logic [9:0]  mem_addr;

   logic [15:0] mem     [DEPTH];
   logic [15:0] ref_mem [DEPTH];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_starve;
   logic [15:0] m_display;
   bit          e_core_chk;
   logic [15:0] e_core_rd, e_dma_rd;
   logic        e_dma_valid;
   logic        last_dgnt;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_core_req     (core_req),
      .i_core_wr_en   (core_wr_en),
      .i_core_addr    (core_addr),
      .i_core_wr_data (core_wr_data),
      .o_core_rd_data (core_rd_data),
      .o_core_stall   (core_stall),
      .i_dma_req      (dma_req),
      .i_dma_wr_en    (dma_wr_en),
      .i_dma_addr     (dma_addr),
      .i_dma_wr_data  (dma_wr_data),
      .o_dma_gnt      (dma_gnt),
      .o_dma_rd_data  (dma_rd_data),
      .o_dma_rd_valid (dma_rd_valid),
      .o_mem_addr     (mem_addr),
      .o_mem_wr_en    (mem_wr_en),
      .o_mem_wr_data  (mem_wr_data),
      .i_mem_rd_data  (mem_rd_data),
      .o_display      (display)
   );

   // Synchronous single-port RAM with read-before-write behaviour.
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      if (a < DEPTH) return ref_mem[a[9:0]];
      if (a == DISP) return m_display;
      return 16'h0000;
   endfunction

   // One clock cycle: apply inputs, check against the model at the falling edge, advance the model.
   task automatic step(input logic creq, input logic cwr, input logic [15:0] caddr, input logic [15:0] cdat,
                       input logic dreq, input logic dwr, input logic [15:0] daddr, input logic [15:0] ddat,
                       input logic r);
      logic        dg, cg, gwr, ew;
      logic [15:0] gaddr, gdat;
      core_req = creq; core_wr_en = cwr; core_addr = caddr; core_wr_data = cdat;
      dma_req = dreq; dma_wr_en = dwr; dma_addr = daddr; dma_wr_data = ddat;
      rst = r;
      @(negedge clk);
      if (r) begin
         e_core_chk = 1'b1; e_core_rd = '0; e_dma_valid = 1'b0; e_dma_rd = '0;
      end
      if (e_core_chk) check("core_rd_data", core_rd_data, e_core_rd);
      check("dma_rd_valid", dma_rd_valid, e_dma_valid);
      check("dma_rd_data", dma_rd_data, e_dma_rd);
      check("display", display, m_display);

      dg = !r && dreq && (!creq || m_starve == LIMIT);
      cg = !r && creq && !dg;
      gwr   = dg ? dwr : cwr;
      gaddr = dg ? daddr : caddr;
      gdat  = dg ? ddat : cdat;
      ew    = (dg || cg) && gwr && (gaddr < DEPTH);
      check("dma_gnt", dma_gnt, dg);
      check("core_stall", core_stall, creq && dg);
      check("mem_wr_en", mem_wr_en, ew);
      if (dg || cg) check("mem_addr", mem_addr, gaddr[9:0]);
      if (ew) check("mem_wr_data", mem_wr_data, gdat);
      last_dgnt = dg;

      if (cg) begin
         e_core_chk = !cwr;
         e_core_rd  = ref_read(caddr);
      end else begin
         e_core_chk = !(dg && daddr == DISP);
         e_core_rd  = '0;
      end
      e_dma_valid = dg && !dwr;
      e_dma_rd    = e_dma_valid ? ref_read(daddr) : 16'h0000;

      if (r) begin
         m_starve  = 0;
         m_display = '0;
      end else begin
         if ((dg || cg) && gwr) begin
            if (gaddr < DEPTH) ref_mem[gaddr[9:0]] = gdat;
            else if (gaddr == DISP) m_display = gdat;
         end
         if (dg) m_starve = 0;
         else if (dreq && m_starve < LIMIT) m_starve++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
   endtask

   function automatic logic [15:0] rand_addr();
      int k = $urandom_range(0, 9);
      if (k < 6) return 16'($urandom_range(0, DEPTH - 1));
      if (k < 8) return DISP;
      return 16'(16'h0400 + $urandom_range(0, 16'hFBFE));
   endfunction

   initial begin
      int          gnt_cycle;
      logic        p_req, p_wr, c_req, c_wr, r;
      logic [15:0] p_addr, p_dat;

      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h0010]     = 16'hBEEF;
      ref_mem[16'h0010] = 16'hBEEF;
      m_starve = 0; m_display = '0;
      e_core_chk = 1'b0; e_core_rd = '0; e_dma_valid = 1'b0; e_dma_rd = '0;

      // Reset with both requesters active: nothing may be granted.
      step(1, 1, 16'h0001, 16'h1111, 1, 1, 16'h0002, 16'h2222, 1);
      step(1, 1, 16'h0001, 16'h1111, 1, 1, 16'h0002, 16'h2222, 1);
      check("starve_after_reset", dut.u_starve.count, 0);

      // Core write then read back.
      step(1, 1, 16'h0003, 16'h0005, 0, 0, 16'h0, 16'h0, 0);
      step(1, 0, 16'h0003, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
      idle();
      check("core_read_back", ref_read(16'h0003), 16'h0005);

      // DMA read with the core idle.
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0, 0);
      idle();

      // Starvation: core busy every cycle, DMA write waits for the limit.
      gnt_cycle = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1, 0, 16'($urandom_range(0, DEPTH - 1)), 16'h0, 1, 1, 16'h0020, 16'hA5A5, 0);
         if (last_dgnt) begin
            gnt_cycle = i;
            break;
         end
      end
      check("starve_grant_cycle", gnt_cycle, LIMIT + 1);
      check("starve_cleared", dut.u_starve.count, 0);
      idle();

      // Display register write and read.
      step(1, 1, DISP, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
      step(1, 0, DISP, 16'h0000, 0, 0, 16'h0, 16'h0, 0);
      idle();
      check("display_value", display, 16'h1234);

      // Out-of-range accesses.
      step(1, 0, 16'h0400, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0800, 16'hDEAD, 0);
      idle();
      check("display_unchanged", display, 16'h1234);

      // Reset right after a DMA read grant discards the read.
      step(0, 0, 16'h0, 16'h0, 1, 0, 16'h0010, 16'h0, 0);
      step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
      idle();
      check("display_after_reset", display, 16'h0000);
      for (int i = 0; i < 3; i++) step(1, 0, 16'h0005, 16'h0, 1, 0, 16'h0011, 16'h0, 0);
      step(1, 0, 16'h0005, 16'h0, 1, 0, 16'h0011, 16'h0, 1);
      check("starve_reset", dut.u_starve.count, 0);
      idle();

      // Random traffic; the DMA holds its request until granted.
      p_req = 0; p_wr = 0; p_addr = '0; p_dat = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p_req || last_dgnt) begin
            p_req  = ($urandom_range(0, 1) == 1);
            p_wr   = ($urandom_range(0, 1) == 1);
            p_addr = rand_addr();
            p_dat  = 16'($urandom);
         end
         c_req = ($urandom_range(0, 9) < 6);
         c_wr  = ($urandom_range(0, 2) == 0);
         r     = ($urandom_range(0, 49) == 0);
         step(c_req, c_wr, rand_addr(), 16'($urandom), p_req, p_wr, p_addr, p_dat, r);
         if (r) p_req = 0;
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
